// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the sequential single-precision multiplier.
package fp_pkg;

    localparam int unsigned BIAS    = 127;
    localparam logic [7:0]  EXP_INF = 8'hFF;
    localparam int unsigned MANT_W  = 24;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned EXP_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp_round.sv
// Combinational normalise + round-to-nearest-even of a 48-bit significand product,
// with overflow to infinity and flush of exponent underflow to signed zero.
module fp_round
    import fp_pkg::*;
(
    input  logic [PROD_W-1:0]       i_prod,
    input  logic signed [EXP_W-1:0] i_exp,
    input  logic                    i_sign,
    output logic [31:0]             o_result_c,
    output logic                    o_ovf_c
);

    logic [22:0]             w_mant;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_up;
    logic [MANT_W-1:0]       w_rnd;
    logic signed [EXP_W-1:0] w_exp_n;
    logic signed [EXP_W-1:0] w_exp_f;

    always_comb begin
        w_mant     = '0;
        w_guard    = 1'b0;
        w_sticky   = 1'b0;
        o_result_c = {i_sign, 31'd0};
        o_ovf_c    = 1'b0;

        // Product of two [1,2) significands lies in [1,4); bit 47 set means one extra shift
        w_exp_n = i_exp + $signed(EXP_W'(i_prod[PROD_W-1]));
        if (i_prod[PROD_W-1]) begin
            w_mant   = i_prod[46:24];
            w_guard  = i_prod[23];
            w_sticky = |i_prod[22:0];
        end else begin
            w_mant   = i_prod[45:23];
            w_guard  = i_prod[22];
            w_sticky = |i_prod[21:0];
        end

        w_up    = w_guard & (w_sticky | w_mant[0]);
        w_rnd   = {1'b0, w_mant} + MANT_W'(w_up);
        // A rounding carry leaves the fraction at zero and bumps the exponent
        w_exp_f = w_exp_n + $signed(EXP_W'(w_rnd[MANT_W-1]));

        // A product with no hidden bit only arises from subnormal operands when flushing is off
        if (!i_prod[PROD_W-1] && !i_prod[PROD_W-2]) begin
            o_result_c = {i_sign, 31'd0};
        end else if (w_exp_f >= 10'sd255) begin
            o_result_c = {i_sign, EXP_INF, 23'd0};
            o_ovf_c    = 1'b1;
        end else if (w_exp_f <= 10'sd0) begin
            o_result_c = {i_sign, 31'd0};
        end else begin
            o_result_c = {i_sign, w_exp_f[7:0], w_rnd[22:0]};
        end
    end

endmodule

// File: rtl/seq_fp_multiplier.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle LSB-first shift-add significand
// product, then one normalise/round cycle; fixed 26-cycle latency for every operand class.
module seq_fp_multiplier
    import fp_pkg::*;
#(
    parameter bit FTZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        inf
);

    logic [7:0]              w_ex;
    logic [7:0]              w_ey;
    logic                    w_x_sub;
    logic                    w_y_sub;
    logic                    w_x_zero;
    logic                    w_y_zero;
    logic                    w_x_inf;
    logic                    w_y_inf;
    logic [MANT_W-1:0]       w_mx;
    logic [MANT_W-1:0]       w_my;
    logic [7:0]              w_ex_eff;
    logic [7:0]              w_ey_eff;
    logic signed [EXP_W-1:0] w_exp_sum;
    logic [31:0]             w_round_res;
    logic                    w_round_ovf;

    state_t                  r_state;
    logic [4:0]              r_cnt;
    logic [PROD_W-1:0]       r_acc;
    logic [PROD_W-1:0]       r_mcand;
    logic [MANT_W-1:0]       r_mplier;
    logic signed [EXP_W-1:0] r_exp;
    logic                    r_sign;
    logic                    r_inf_op;
    logic                    r_zero_op;

    // Operand classification; without flushing a subnormal enters as {0,frac} with exponent 1
    assign w_ex      = X[30:23];
    assign w_ey      = Y[30:23];
    assign w_x_sub   = (w_ex == 8'd0);
    assign w_y_sub   = (w_ey == 8'd0);
    assign w_x_zero  = w_x_sub && (FTZ || (X[22:0] == 23'd0));
    assign w_y_zero  = w_y_sub && (FTZ || (Y[22:0] == 23'd0));
    assign w_x_inf   = (w_ex == EXP_INF);
    assign w_y_inf   = (w_ey == EXP_INF);
    assign w_mx      = w_x_zero ? '0 : {~w_x_sub, X[22:0]};
    assign w_my      = w_y_zero ? '0 : {~w_y_sub, Y[22:0]};
    assign w_ex_eff  = w_x_sub ? 8'd1 : w_ex;
    assign w_ey_eff  = w_y_sub ? 8'd1 : w_ey;
    assign w_exp_sum = $signed({2'b00, w_ex_eff}) + $signed({2'b00, w_ey_eff})
                     - $signed(EXP_W'(BIAS));

    fp_round u_round (
        .i_prod     (r_acc),
        .i_exp      (r_exp),
        .i_sign     (r_sign),
        .o_result_c (w_round_res),
        .o_ovf_c    (w_round_ovf)
    );

    // Control FSM and shift-add datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_inf_op  <= 1'b0;
            r_zero_op <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Result    <= '0;
            inf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= MUL;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_mcand   <= PROD_W'(w_mx);
                        r_mplier  <= w_my;
                        r_exp     <= w_exp_sum;
                        r_sign    <= X[31] ^ Y[31];
                        r_inf_op  <= w_x_inf | w_y_inf;
                        r_zero_op <= w_x_zero | w_y_zero;
                    end
                end
                MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'(MANT_W - 1)) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_state <= DONE;
                    done    <= 1'b1;
                    // Infinity/NaN operands dominate zero operands
                    if (r_inf_op) begin
                        Result <= {r_sign, EXP_INF, 23'd0};
                        inf    <= 1'b1;
                    end else if (r_zero_op) begin
                        Result <= {r_sign, 31'd0};
                        inf    <= 1'b0;
                    end else begin
                        Result <= w_round_res;
                        inf    <= w_round_ovf;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fp_multiplier.sv
// Directed bench for seq_fp_multiplier: expected results queued at issue, checked on done.
module tb_seq_fp_multiplier;

    typedef struct packed {
        logic [31:0] res;
        logic        inf;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        inf;

    int total = 0;
    int bad   = 0;
    sb_entry_t sb[$];

    seq_fp_multiplier #(.FTZ(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .X      (X),
        .Y      (Y),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .inf    (inf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Called at a point just after a falling edge; the accept edge is the next rising edge.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eres, input logic einf,
                          input int restart_cyc, input int rst_cyc);
        sb_entry_t e;
        X     = x;
        Y     = y;
        start = 1'b1;
        sb.push_back('{res: eres, inf: einf});
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (k == restart_cyc) begin
                X     = 32'h3F800000;
                Y     = 32'h3F800000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (rst_cyc != 0 && k == rst_cyc) begin
                rst = 1'b1;
                sb.delete();
            end
            #1;
            if (rst_cyc != 0 && k >= rst_cyc) begin
                check($sformatf("abort_busy_c%0d", k), 32'(busy), 32'd0);
                check($sformatf("abort_done_c%0d", k), 32'(done), 32'd0);
                check($sformatf("abort_result_c%0d", k), Result, 32'd0);
            end else begin
                check($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= 26));
                check($sformatf("done_c%0d", k), 32'(done), 32'(k == 26));
                if (done) begin
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check($sformatf("result_%h_%h", x, y), Result, e.res);
                        check($sformatf("inf_%h_%h", x, y), 32'(inf), 32'(e.inf));
                    end
                end
                if (k == 28) begin
                    check($sformatf("held_%h_%h", x, y), Result, eres);
                end
            end
        end
        X = '0;
        Y = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_inf", 32'(inf), 32'd0);
        rst = 1'b0;

        // Basic products and sign handling
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 0, 0);
        run_op(32'h3FC00000, 32'hBFC00000, 32'hC0100000, 1'b0, 0, 0);
        // Rounding: sticky only, ties to odd/even neighbours, carry out of rounding
        run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 0, 0);
        run_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 0, 0);
        run_op(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 0, 0);
        run_op(32'h3F918E00, 32'h3FE12000, 32'h40000000, 1'b0, 0, 0);
        // Infinity/NaN operands and exponent overflow
        run_op(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 0, 0);
        run_op(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 0, 0);
        run_op(32'h7FC00000, 32'hBF800000, 32'hFF800000, 1'b1, 0, 0);
        run_op(32'h80000000, 32'h7F800000, 32'hFF800000, 1'b1, 0, 0);
        // Zeros, subnormal flush and exponent underflow
        run_op(32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 0, 0);
        run_op(32'h00400000, 32'h40000000, 32'h00000000, 1'b0, 0, 0);
        run_op(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 0, 0);
        // Second start while busy must be ignored
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 5, 0);
        // Reset mid-operation, then a start on the first edge after release
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 0, 10);
        rst = 1'b0;
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
